sqrt_lut_init: RTL and testbench
================================

SQRT_LUT_INIT -- requirements
Module: sqrt_lut_init

Interface
REQ-001 Parameter DIN_WIDTH, 16: LUT address width; table holds 2**DIN_WIDTH entries; address is unsigned input code.
REQ-002 Parameter DIN_POINT, 10: fractional bits of the address interpretation.
REQ-003 Parameter DOUT_WIDTH, 16: table word width.
REQ-004 Parameter DOUT_POINT, 12: fractional bits of the stored root.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle pulse requesting a full table build.
REQ-008 busy  out  1  high while a build is in progress.
REQ-009 done  out  1  sticky completion flag.
REQ-010 wen  out  1  table write strobe.
REQ-011 wadd  out  DIN_WIDTH  table write address.
REQ-012 win  out  DOUT_WIDTH  table write data.
REQ-013 wready  in  1  table sink accepts the write when wen and wready are both high.

Function
REQ-014 Entry a SHALL hold floor(sqrt(a * 2**SHIFT)), with SHIFT = 2*DOUT_POINT - DIN_POINT; SHIFT < 0 SHALL be rejected at elaboration.
REQ-015 Radicand width RAD_W SHALL be DIN_WIDTH+SHIFT rounded up to even; ITER = RAD_W/2 root bits.
REQ-016 Root SHALL be computed bit-serially, one root bit per cycle, MSB first, with the restoring digit-by-digit method; no multipliers, no divider.
REQ-017 Roots exceeding 2**DOUT_WIDTH-1 SHALL saturate to 2**DOUT_WIDTH-1.
REQ-018 FSM states: IDLE, LOAD, CALC, WRITE, FIN.
REQ-019 IDLE: start=1 -> LOAD; clears done, sets busy, address counter = 0.
REQ-020 LOAD (1 cycle): radicand = address << SHIFT, remainder = 0, root = 0 -> CALC.
REQ-021 CALC: exactly ITER cycles, then -> WRITE.
REQ-022 WRITE: wen=1 with wadd=address, win=root; held stable until wready=1.
REQ-023 On accepted write: last address -> FIN; otherwise address+1 -> LOAD.
REQ-024 FIN (1 cycle): busy=0, done=1 -> IDLE.
REQ-025 Per-entry cost with wready held high: ITER+2 cycles; table build = 2**DIN_WIDTH*(ITER+2)+1 cycles from start to done.
REQ-026 start while busy SHALL be ignored; no restart, no counter change.
REQ-027 start in IDLE with done=1 SHALL rebuild the whole table from address 0.
REQ-028 Address counter SHALL not wrap; the last address is 2**DIN_WIDTH-1.
REQ-029 wen SHALL be 0 in every state except WRITE; wadd/win SHALL not change while wen=1 and wready=0.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, wen=0, wadd=0, win=0, internal registers 0.
REQ-031 Reset mid-build SHALL abandon the build with no further writes; table contents are undefined until a new start completes.
REQ-032 Reset deassertion SHALL not by itself start a build.

Structure
REQ-033 FSM state encoding and the SHIFT/RAD_W/ITER derivations SHALL live in a shared package, reused by sqrt readers.
REQ-034 The bit-serial root engine SHALL be one sub-module, sqrt_serial_core (load, step, root out, ready after ITER steps); the top holds FSM, address counter and write port.

Verification
REQ-035 DIN_WIDTH=4, DIN_POINT=0, DOUT_WIDTH=4, DOUT_POINT=1, wready=1, start pulse -> 16 writes, addresses 0..15, data 0,2,2,3,4,4,4,5,5,6,6,6,6,7,7,7; done rises 81 cycles after start.
REQ-036 Same parameters, DOUT_WIDTH=2 -> data 0,2,2,3 then 3 for addresses 4..15 (saturation).
REQ-037 wready low 5 cycles during address 7 write -> wen, wadd=7, win=5 held stable 5 cycles; sequence otherwise unchanged; done delayed by 5 cycles.
REQ-038 start pulsed again at address 3 while busy -> ignored; exactly 16 writes, single done.
REQ-039 rst_n low at address 9 in CALC -> wen=0, busy=0, done=0 immediately; no write for address 9; later start rebuilds from address 0.
REQ-040 Default parameters, random addresses sampled after build -> stored value equals floor(sqrt(a*2**14)) for every sample.

Source files
------------

// File: rtl/sqrt_lut_init_pkg.sv
// Shared definitions for the square-root LUT builder and its readers:
// FSM state codes and the fixed-point derivations of the radicand/root widths.
package sqrt_lut_init_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    // Left shift that aligns the address binary point with the squared root point.
    function automatic int sqrt_shift(input int din_point, input int dout_point);
        return 2 * dout_point - din_point;
    endfunction

    // Radicand width, rounded up to even so it splits into whole bit pairs.
    function automatic int sqrt_rad_w(input int din_width, input int shift);
        int w;
        w = din_width + shift;
        return w + (w % 2);
    endfunction

    function automatic int sqrt_iter(input int rad_w);
        return rad_w / 2;
    endfunction

endpackage

// File: rtl/sqrt_lut_init_core.sv
// Restoring digit-by-digit square root: one root bit per step, MSB first,
// consuming the radicand two bits at a time. Only shifts, compare and subtract.
module sqrt_serial_core #(
    parameter int RAD_W = 6,
    parameter int ITER  = RAD_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [RAD_W-1:0] rad_i,
    output logic [ITER-1:0]  root_o,
    output logic             ready_o,
    output logic             last_o
);

    // Remainder never exceeds 2*root, so ITER+2 bits cover the shifted trial value.
    localparam int REM_W = ITER + 2;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [RAD_W-1:0] rad_q, rad_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [ITER-1:0]  root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;

    assign ready_o = (cnt_q == CNT_W'(ITER));
    assign last_o  = step_i && (cnt_q == CNT_W'(ITER - 1));
    assign root_o  = root_q;

    always_comb begin
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        rem_sh = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
        trial  = (REM_W'(root_q) << 2) | REM_W'(1);
        if (load_i) begin
            rad_d  = rad_i;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
        end else if (step_i && !ready_o) begin
            rad_d = rad_q << 2;
            cnt_d = cnt_q + 1'b1;
            if (rem_sh >= trial) begin
                rem_d  = rem_sh - trial;
                root_d = (root_q << 1) | ITER'(1);
            end else begin
                rem_d  = rem_sh;
                root_d = root_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sqrt_lut_init.sv
// Builds a square-root lookup table: for every address computes the fixed-point
// root bit-serially and pushes it out through a valid/ready write port.
module sqrt_lut_init
    import sqrt_lut_init_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_POINT  = 10,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_POINT = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  wen,
    output logic [DIN_WIDTH-1:0]  wadd,
    output logic [DOUT_WIDTH-1:0] win,
    input  logic                  wready,
    output logic [2:0]            state_o
);

    localparam int SHIFT = sqrt_shift(DIN_POINT, DOUT_POINT);
    localparam int RAD_W = sqrt_rad_w(DIN_WIDTH, SHIFT);
    localparam int ITER  = sqrt_iter(RAD_W);

    if (SHIFT < 0) begin : g_bad_shift
        $error("sqrt_lut_init: 2*DOUT_POINT must be >= DIN_POINT");
    end

    // Write handshake: a write is transferred on a rising edge where wen and
    // wready are both high; wadd/win stay frozen while wen waits for wready.
    logic [2:0]           state_q, state_d;
    logic [DIN_WIDTH-1:0] addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 core_load, core_step, core_ready, core_last;
    logic [ITER-1:0]      core_root;
    logic [RAD_W-1:0]     core_rad;

    assign core_rad = RAD_W'(addr_q) << SHIFT;

    sqrt_serial_core #(
        .RAD_W (RAD_W),
        .ITER  (ITER)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (core_load),
        .step_i  (core_step),
        .rad_i   (core_rad),
        .root_o  (core_root),
        .ready_o (core_ready),
        .last_o  (core_last)
    );

    if (ITER > DOUT_WIDTH) begin : g_sat
        assign win = (|core_root[ITER-1:DOUT_WIDTH]) ? {DOUT_WIDTH{1'b1}}
                                                     : core_root[DOUT_WIDTH-1:0];
    end else begin : g_nosat
        assign win = DOUT_WIDTH'(core_root);
    end

    assign wen     = (state_q == S_WRITE) && core_ready;
    assign wadd    = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                core_load = 1'b1;
                state_d   = S_CALC;
            end
            S_CALC: begin
                core_step = 1'b1;
                if (core_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wen && wready) begin
                    if (addr_q == {DIN_WIDTH{1'b1}}) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sqrt_lut_init.sv
// Scoreboard bench for sqrt_lut_init: two small tables (plain and saturating)
// share stimulus; a wider table is built with random back-pressure and sampled.
module tb_sqrt_lut_init;
    import sqrt_lut_init_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, wready, start_c, wready_c;
    logic busy_a, done_a, wen_a; logic [3:0] wadd_a, win_a; logic [2:0] state_a;
    logic busy_b, done_b, wen_b; logic [3:0] wadd_b; logic [1:0] win_b; logic [2:0] state_b;
    logic busy_c, done_c, wen_c; logic [9:0] wadd_c; logic [15:0] win_c; logic [2:0] state_c;

    int checks = 0;
    int errors = 0;
    int writes_a = 0, writes_b = 0, writes_c = 0;
    logic [7:0]  exp_a_q[$];
    logic [5:0]  exp_b_q[$];
    logic [25:0] exp_c_q[$];
    logic [15:0] table_c [1024];

    sqrt_lut_init #(.DIN_WIDTH(4), .DIN_POINT(0), .DOUT_WIDTH(4), .DOUT_POINT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a), .wen(wen_a),
        .wadd(wadd_a), .win(win_a), .wready(wready), .state_o(state_a));

    sqrt_lut_init #(.DIN_WIDTH(4), .DIN_POINT(0), .DOUT_WIDTH(2), .DOUT_POINT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b), .wen(wen_b),
        .wadd(wadd_b), .win(win_b), .wready(wready), .state_o(state_b));

    sqrt_lut_init #(.DIN_WIDTH(10), .DIN_POINT(10), .DOUT_WIDTH(16), .DOUT_POINT(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c), .wen(wen_c),
        .wadd(wadd_c), .win(win_c), .wready(wready_c), .state_o(state_c));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= a*2**shift, clipped to the word range.
    function automatic longint ref_root(input longint a, input int shift, input int dout_w);
        longint n, r, mx;
        n = a << shift;
        r = longint'($floor($sqrt(real'(n))));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        mx = (longint'(1) << dout_w) - 1;
        return (r > mx) ? mx : r;
    endfunction

    task automatic push_ab(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            exp_a_q.push_back({4'(a), 4'(ref_root(a, 2, 4))});
            exp_b_q.push_back({4'(a), 2'(ref_root(a, 2, 2))});
        end
    endtask

    // Leaves the caller at #1 after the edge that samples start.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_addr_a(input logic [3:0] addr, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy_a && wadd_a == addr) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        wready_c = 1'b1;
        forever begin
            @(posedge clk); #1;
            wready_c = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the expected queue on every accepted write.
    logic        hold_pend = 1'b0;
    logic [25:0] hold_val;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && wen_a && wready) begin
                writes_a++;
                if (exp_a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_write: got addr %0d, expected no write", wadd_a);
                end else check("a_write", {wadd_a, win_a}, exp_a_q.pop_front());
            end
            if (rst_n && wen_b && wready) begin
                writes_b++;
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_write: got addr %0d, expected no write", wadd_b);
                end else check("b_write", {wadd_b, win_b}, exp_b_q.pop_front());
            end
            if (rst_n) begin
                if (hold_pend) check("c_hold_stable", {wen_c, wadd_c, win_c}, {1'b1, hold_val});
                hold_pend = wen_c && !wready_c;
                hold_val  = {wadd_c, win_c};
                if (wen_c && wready_c) begin
                    writes_c++;
                    table_c[wadd_c] = win_c;
                    if (exp_c_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL c_unexpected_write: got addr %0d, expected no write", wadd_c);
                    end else check("c_write", {wadd_c, win_c}, exp_c_q.pop_front());
                end
            end
        end
    end

    initial begin
        int cyc, w0;
        bit seen;
        rst_n = 1'b0; start = 1'b0; wready = 1'b1; start_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_wen", wen_a, 0);
        check("rst_wadd", wadd_a, 0);
        check("rst_win", win_a, 0);
        check("rst_state", state_a, S_IDLE);
        check("rst_c_busy", {busy_c, done_c, wen_c}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_auto_start", {busy_a, wen_a, done_a}, 0);

        // Plain build, wready held high.
        push_ab(0, 15);
        w0 = writes_a;
        pulse_start();
        check("b1_busy_set", {busy_a, done_a}, 2'b10);
        wait_done(300, cyc);
        check("b1_latency", cyc, 81);
        check("b1_writes", writes_a - w0, 16);
        check("b1_queue_a", exp_a_q.size(), 0);
        check("b1_queue_b", exp_b_q.size(), 0);
        check("b1_done_b", {busy_b, done_b}, 2'b01);

        // Rebuild from done, with a 5-cycle stall on the address 7 write.
        push_ab(0, 15);
        w0 = writes_a;
        pulse_start();
        check("b2_done_cleared", {busy_a, done_a}, 2'b10);
        fork
            begin
                wait_addr_a(4'd7, seen);
                while (seen && !wen_a) begin @(posedge clk); #1; end
                check("b2_stall_trigger", seen, 1);
                wready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("b2_stall_hold", {wen_a, wadd_a, win_a, win_b}, {1'b1, 4'd7, 4'd5, 2'd3});
                end
                wready = 1'b1;
            end
            wait_done(400, cyc);
        join
        check("b2_latency", cyc, 86);
        check("b2_writes", writes_a - w0, 16);
        check("b2_queue_a", exp_a_q.size(), 0);

        // Second start while busy must be ignored.
        push_ab(0, 15);
        w0 = writes_a;
        pulse_start();
        fork
            begin
                wait_addr_a(4'd3, seen);
                check("b3_restart_trigger", seen, 1);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                check("b3_no_restart", (wadd_a == 4'd3) || (wadd_a == 4'd4), 1);
            end
            wait_done(300, cyc);
        join
        check("b3_latency", cyc, 81);
        check("b3_writes", writes_a - w0, 16);
        repeat (20) @(posedge clk);
        #1;
        check("b3_single_done", {busy_a, done_a}, 2'b01);
        check("b3_no_extra_writes", writes_a - w0, 16);

        // Reset while computing address 9.
        push_ab(0, 8);
        w0 = writes_a;
        pulse_start();
        wait_addr_a(4'd9, seen);
        check("b4_reach_9", seen, 1);
        @(posedge clk); #1;
        check("b4_in_calc", state_a, S_CALC);
        rst_n = 1'b0;
        #1;
        check("b4_rst_outputs", {wen_a, busy_a, done_a, wadd_a}, 0);
        check("b4_queue_a", exp_a_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("b4_writes", writes_a - w0, 9);
        check("b4_idle_after", {busy_a, done_a}, 0);

        // Full rebuild after the abandoned one.
        push_ab(0, 15);
        w0 = writes_a;
        pulse_start();
        wait_done(300, cyc);
        check("b5_latency", cyc, 81);
        check("b5_writes", writes_a - w0, 16);
        check("b5_queue_b", exp_b_q.size(), 0);

        // Wide table under random back-pressure.
        for (int a = 0; a < 1024; a++)
            exp_c_q.push_back({10'(a), 16'(ref_root(a, 14, 16))});
        w0 = writes_c;
        @(posedge clk); #1 start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            if (done_c) begin
                seen = 1'b1;
                break;
            end
        end
        check("c_done", seen, 1);
        check("c_writes", writes_c - w0, 1024);
        check("c_queue", exp_c_q.size(), 0);
        check("c_first", table_c[0], 0);
        check("c_last", table_c[1023], ref_root(1023, 14, 16));
        for (int k = 0; k < 24; k++) begin
            int a;
            a = $urandom_range(0, 1023);
            check("c_sample", table_c[a], ref_root(a, 14, 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
